// File: rtl/fir_sample_sched.sv
// Sample-rate sequencer for the FIR datapaths: tick generation, input buffering,
// latency tracking, result handshake and coefficient bank reload with flush.
module fir_sample_sched #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 16,
  parameter int FIR_LENGTH = 51,
  parameter int CLK_DIV    = 250,
  parameter int PIPE_LAT   = 2,
  parameter int ADDR_W     = $clog2(FIR_LENGTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] o_fir_data,
  output logic                  o_fir_en,
  input  logic [DATA_WIDTH-1:0] i_fir_data,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  input  logic                  i_cfg_we,
  input  logic [ADDR_W-1:0]     i_cfg_addr,
  input  logic [COEF_WIDTH-1:0] i_cfg_data,
  input  logic                  i_cfg_commit,
  output logic                  o_cfg_busy,
  output logic                  o_coef_we,
  output logic [ADDR_W-1:0]     o_coef_addr,
  output logic [COEF_WIDTH-1:0] o_coef_data,
  output logic                  o_bank_swap,
  output logic                  o_underrun,
  output logic                  o_overrun,
  input  logic                  i_clr_status
);

  localparam int CNT_W       = $clog2(CLK_DIV);
  localparam int FLUSH_TICKS = FIR_LENGTH + PIPE_LAT;
  localparam int FL_W        = $clog2(FLUSH_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, SWAP_WAIT, FLUSH} state_t;

  state_t                  state_q, state_d, resume_q, resume_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FL_W-1:0]         flush_q, flush_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [PIPE_LAT-1:0]     lat_q, lat_d;
  logic [DATA_WIDTH-1:0]   fir_data_q, fir_data_d;
  logic                    fir_en_q, fir_en_d;
  logic                    swap_q, swap_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    under_q, under_d;
  logic                    over_q, over_d;
  logic                    coef_we_q, coef_we_d;
  logic [ADDR_W-1:0]       coef_addr_q, coef_addr_d;
  logic [COEF_WIDTH-1:0]   coef_data_q, coef_data_d;

  logic tick, busy, res_cap, addr_ok;

  always_comb begin
    busy    = (state_q == SWAP_WAIT) || (state_q == FLUSH);
    // Ticks are suppressed in the cycle enable drops so no half-processed sample slot is left behind.
    tick    = (state_q != IDLE) && i_enable && (cnt_q == CNT_W'(CLK_DIV - 1));
    res_cap = tick && lat_q[PIPE_LAT-1] && (state_q == RUN);
    addr_ok = {1'b0, i_cfg_addr} < (ADDR_W + 1)'(FIR_LENGTH);

    state_d      = state_q;
    resume_d     = resume_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    lat_d        = lat_q;
    fir_data_d   = fir_data_q;
    fir_en_d     = tick;
    swap_d       = tick && (state_q == SWAP_WAIT);
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    under_d      = under_q;
    over_d       = over_q;
    coef_we_d    = !busy && i_cfg_we && addr_ok;
    coef_addr_d  = coef_addr_q;
    coef_data_d  = coef_data_q;

    unique case (state_q)
      IDLE:      if (i_enable) state_d = resume_q;
      RUN:       if (i_cfg_commit) state_d = SWAP_WAIT;
      SWAP_WAIT: if (tick) state_d = FLUSH;
      FLUSH:     if (tick && (flush_q == FL_W'(FLUSH_TICKS - 1))) state_d = RUN;
      default:   state_d = IDLE;
    endcase
    // Remember where we were so a swap or flush in progress resumes (flush restarts in full).
    if (!i_enable) begin
      state_d = IDLE;
      if (state_q != IDLE) resume_d = state_q;
    end

    if (state_q == IDLE || !i_enable) cnt_d = '0;
    else if (tick)                    cnt_d = '0;
    else                              cnt_d = cnt_q + CNT_W'(1);

    if (state_q != FLUSH) flush_d = '0;
    else if (tick)        flush_d = flush_q + FL_W'(1);

    if (tick) begin
      fir_data_d   = hold_valid_q ? hold_data_q : '0;
      lat_d        = PIPE_LAT'({lat_q, hold_valid_q});
      hold_valid_d = 1'b0;
    end
    if (i_s_valid && o_s_ready) begin
      hold_valid_d = 1'b1;
      hold_data_d  = i_s_data;
    end

    if (res_cap) begin
      m_data_d  = i_fir_data;
      m_valid_d = 1'b1;
    end else if (i_m_ready) begin
      m_valid_d = 1'b0;
    end

    if (tick && !hold_valid_q)                  under_d = 1'b1;
    else if (i_clr_status)                      under_d = 1'b0;
    if (res_cap && m_valid_q && !i_m_ready)     over_d  = 1'b1;
    else if (i_clr_status)                      over_d  = 1'b0;

    if (coef_we_d) begin
      coef_addr_d = i_cfg_addr;
      coef_data_d = i_cfg_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      resume_q     <= RUN;
      cnt_q        <= '0;
      flush_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      lat_q        <= '0;
      fir_data_q   <= '0;
      fir_en_q     <= 1'b0;
      swap_q       <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      under_q      <= 1'b0;
      over_q       <= 1'b0;
      coef_we_q    <= 1'b0;
      coef_addr_q  <= '0;
      coef_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      resume_q     <= resume_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      lat_q        <= lat_d;
      fir_data_q   <= fir_data_d;
      fir_en_q     <= fir_en_d;
      swap_q       <= swap_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      under_q      <= under_d;
      over_q       <= over_d;
      coef_we_q    <= coef_we_d;
      coef_addr_q  <= coef_addr_d;
      coef_data_q  <= coef_data_d;
    end
  end

  assign o_s_ready   = !hold_valid_q || tick;
  assign o_fir_data  = fir_data_q;
  assign o_fir_en    = fir_en_q;
  assign o_m_data    = m_data_q;
  assign o_m_valid   = m_valid_q;
  assign o_cfg_busy  = busy;
  assign o_coef_we   = coef_we_q;
  assign o_coef_addr = coef_addr_q;
  assign o_coef_data = coef_data_q;
  assign o_bank_swap = swap_q;
  assign o_underrun  = under_q;
  assign o_overrun   = over_q;

endmodule

// File: tb/tb_fir_sample_sched.sv
// Randomized bench for fir_sample_sched against a transaction-level reference model.
module tb_fir_sample_sched;

  localparam int DW = 24;
  localparam int CW = 16;
  localparam int FL = 5;
  localparam int CD = 4;
  localparam int PL = 2;
  localparam int AW = $clog2(FL);

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [DW-1:0] i_s_data = '0;
  logic          i_s_valid = 1'b0;
  logic          o_s_ready;
  logic [DW-1:0] o_fir_data;
  logic          o_fir_en;
  logic [DW-1:0] i_fir_data = '0;
  logic [DW-1:0] o_m_data;
  logic          o_m_valid;
  logic          i_m_ready = 1'b0;
  logic          i_cfg_we = 1'b0;
  logic [AW-1:0] i_cfg_addr = '0;
  logic [CW-1:0] i_cfg_data = '0;
  logic          i_cfg_commit = 1'b0;
  logic          o_cfg_busy;
  logic          o_coef_we;
  logic [AW-1:0] o_coef_addr;
  logic [CW-1:0] o_coef_data;
  logic          o_bank_swap;
  logic          o_underrun;
  logic          o_overrun;
  logic          i_clr_status = 1'b0;

  always #5 i_clk = ~i_clk;

  fir_sample_sched #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .FIR_LENGTH(FL),
    .CLK_DIV(CD), .PIPE_LAT(PL), .ADDR_W(AW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_fir_data(o_fir_data), .o_fir_en(o_fir_en), .i_fir_data(i_fir_data),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .i_cfg_commit(i_cfg_commit), .o_cfg_busy(o_cfg_busy),
    .o_coef_we(o_coef_we), .o_coef_addr(o_coef_addr), .o_coef_data(o_coef_data),
    .o_bank_swap(o_bank_swap), .o_underrun(o_underrun), .o_overrun(o_overrun),
    .i_clr_status(i_clr_status)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: run flag, phase within the sample period, pending swap,
  // remaining flush ticks, a one-deep sample queue and a queue of in-flight slot validities.
  bit            running, swap_req;
  int            flush_left, phase;
  logic [DW-1:0] held[$];
  bit            slots[$];
  logic [DW-1:0] e_fir_data, e_m_data;
  bit            e_fir_en, e_swap, e_m_valid, e_under, e_over, e_coef_we;
  logic [AW-1:0] e_caddr;
  logic [CW-1:0] e_cdata;
  int            dir_addr = -1;
  logic [CW-1:0] dir_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    running = 0; swap_req = 0; flush_left = 0; phase = 0;
    held.delete(); slots.delete();
    for (int i = 0; i < PL; i++) slots.push_back(1'b0);
    e_fir_data = '0; e_m_data = '0; e_fir_en = 0; e_swap = 0; e_m_valid = 0;
    e_under = 0; e_over = 0; e_coef_we = 0; e_caddr = '0; e_cdata = '0;
  endtask

  task automatic check_all();
    bit e_ready;
    e_ready = (held.size() == 0) || (running && phase == CD - 1 && i_enable);
    check("s_ready",   32'(o_s_ready),   32'(e_ready));
    check("fir_en",    32'(o_fir_en),    32'(e_fir_en));
    check("fir_data",  32'(o_fir_data),  32'(e_fir_data));
    check("bank_swap", 32'(o_bank_swap), 32'(e_swap));
    check("m_valid",   32'(o_m_valid),   32'(e_m_valid));
    check("m_data",    32'(o_m_data),    32'(e_m_data));
    check("underrun",  32'(o_underrun),  32'(e_under));
    check("overrun",   32'(o_overrun),   32'(e_over));
    check("cfg_busy",  32'(o_cfg_busy),  32'(running && (swap_req || flush_left > 0)));
    check("coef_we",   32'(o_coef_we),   32'(e_coef_we));
    check("coef_addr", 32'(o_coef_addr), 32'(e_caddr));
    check("coef_data", 32'(o_coef_data), 32'(e_cdata));
  endtask

  // Predicts the effect of the coming clock edge from the inputs now applied.
  task automatic model_step();
    bit tick, run_now, busy, hv, tail, cap, set_u, set_o;
    tick    = running && phase == CD - 1 && i_enable;
    run_now = running && !swap_req && flush_left == 0;
    busy    = running && !run_now;
    hv      = held.size() != 0;
    cap     = 0;
    e_fir_en = tick;
    e_swap   = tick && swap_req;
    set_u    = tick && !hv;
    if (tick) begin
      e_fir_data = hv ? held[0] : '0;
      tail = slots.pop_front();
      slots.push_back(hv);
      cap = tail && run_now;
    end
    set_o = cap && e_m_valid && !i_m_ready;
    if (cap) begin
      e_m_data = i_fir_data;
      e_m_valid = 1;
    end else if (i_m_ready) e_m_valid = 0;
    e_under = set_u ? 1'b1 : (i_clr_status ? 1'b0 : e_under);
    e_over  = set_o ? 1'b1 : (i_clr_status ? 1'b0 : e_over);
    e_coef_we = !busy && i_cfg_we && (int'(i_cfg_addr) < FL);
    if (e_coef_we) begin
      e_caddr = i_cfg_addr;
      e_cdata = i_cfg_data;
    end
    if (tick && hv) void'(held.pop_front());
    if (i_s_valid && (!hv || tick)) held.push_back(i_s_data);
    if (!i_enable) begin
      running = 0; phase = 0;
      if (flush_left > 0) flush_left = FL + PL;
    end else if (!running) begin
      running = 1; phase = 0;
    end else begin
      phase = (phase + 1) % CD;
      if (tick) begin
        if (swap_req) begin
          swap_req = 0;
          flush_left = FL + PL;
        end else if (flush_left > 0) flush_left--;
      end
      if (run_now && i_cfg_commit) swap_req = 1;
    end
  endtask

  task automatic cycle(input bit en, input int pv, input int pr, input int pw,
                       input int pc, input int pclr);
    @(negedge i_clk);
    check_all();
    i_enable     = en;
    i_s_valid    = ($urandom % 100) < pv;
    i_s_data     = DW'($urandom);
    i_m_ready    = ($urandom % 100) < pr;
    i_fir_data   = DW'($urandom);
    i_cfg_we     = ($urandom % 100) < pw;
    i_cfg_addr   = (dir_addr >= 0) ? AW'(dir_addr) : AW'($urandom_range(0, 7));
    i_cfg_data   = (dir_addr >= 0) ? dir_data : CW'($urandom);
    i_cfg_commit = ($urandom % 100) < pc;
    i_clr_status = ($urandom % 100) < pclr;
    model_step();
  endtask

  task automatic quiet_inputs();
    i_enable = 0; i_s_valid = 0; i_m_ready = 0; i_cfg_we = 0;
    i_cfg_commit = 0; i_clr_status = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      @(negedge i_clk);
      check_all();
    end
    i_rst_n = 1'b1;
    model_step();

    // Steady stream with an always-ready sink.
    repeat (40) cycle(1, 100, 100, 0, 0, 0);
    // Starved input, then clear the sticky flag while refilling.
    repeat (12) cycle(1, 0, 100, 0, 0, 0);
    repeat (3)  cycle(1, 100, 100, 0, 0, 100);
    // Stalled sink overwrites results, then accept.
    repeat (20) cycle(1, 100, 0, 0, 0, 0);
    repeat (6)  cycle(1, 100, 100, 0, 0, 0);
    // Coefficient write at index 2, commit, then writes offered through the swap and flush.
    dir_addr = 2; dir_data = 16'h1234;
    cycle(1, 100, 100, 100, 0, 0);
    dir_addr = -1;
    cycle(1, 100, 100, 0, 0, 0);
    cycle(1, 100, 100, 0, 100, 0);
    repeat (45) cycle(1, 100, 100, 60, 0, 0);
    // Disable during the flush, then resume into a fresh flush.
    cycle(1, 100, 100, 0, 100, 0);
    repeat (15) cycle(1, 100, 100, 0, 0, 0);
    repeat (5)  cycle(0, 100, 100, 0, 0, 0);
    repeat (45) cycle(1, 100, 100, 0, 0, 0);
    // Random mix of all controls.
    repeat (600) cycle(($urandom % 40) != 0, 70, 60, 20, 3, 5);
    // Stalled sink, commit, then reset while flushing with a result pending.
    repeat (30) cycle(1, 100, 0, 0, 0, 0);
    cycle(1, 100, 0, 0, 100, 0);
    repeat (12) cycle(1, 100, 0, 0, 0, 0);
    @(negedge i_clk);
    check_all();
    check("pre_reset_m_valid", 32'(o_m_valid), 32'(1));
    quiet_inputs();
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge i_clk);
    check_all();
    i_rst_n = 1'b1;
    model_step();
    repeat (20) cycle(1, 100, 100, 0, 0, 0);
    @(negedge i_clk);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_sample_sched.md
Name: fir_sample_sched

Overview:
- Sequencing controller for the team's FIR filter datapaths (symmetric, transposed-form).
- Generates the per-sample enable strobe from the fast system clock and buffers one input sample behind a valid/ready interface.
- Feeds the filter, tracks filter latency, and presents results on an output valid/ready interface.
- Manages runtime coefficient reload into the filter's shadow bank, with a bank swap on a sample boundary followed by a flush window that suppresses mixed-coefficient outputs.

Parameters:
- DATA_WIDTH, 24, sample width (input and output).
- COEF_WIDTH, 16, coefficient width.
- FIR_LENGTH, 51, number of taps; sets flush length and coefficient address range.
- CLK_DIV, 250, i_clk cycles per sample tick (≥ 4).
- PIPE_LAT, 2, ticks from sample presented to its result on i_fir_data.
- ADDR_W, $clog2(FIR_LENGTH), coefficient address width.

Ports:
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_enable, in, 1, run enable.
- i_s_data, in, DATA_WIDTH, input sample (signed).
- i_s_valid, in, 1, input sample valid.
- o_s_ready, out, 1, holding register can accept.
- o_fir_data, out, DATA_WIDTH, sample driven to the filter.
- o_fir_en, out, 1, one-cycle filter clock-enable strobe.
- i_fir_data, in, DATA_WIDTH, filter output.
- o_m_data, out, DATA_WIDTH, filtered result.
- o_m_valid, out, 1, result valid.
- i_m_ready, in, 1, downstream accepts.
- i_cfg_we, in, 1, coefficient write strobe.
- i_cfg_addr, in, ADDR_W, coefficient index.
- i_cfg_data, in, COEF_WIDTH, coefficient value.
- i_cfg_commit, in, 1, request bank swap.
- o_cfg_busy, out, 1, high in SWAP_WAIT/FLUSH; config writes ignored.
- o_coef_we, out, 1, shadow-bank write strobe.
- o_coef_addr, out, ADDR_W, shadow-bank address.
- o_coef_data, out, COEF_WIDTH, shadow-bank data.
- o_bank_swap, out, 1, one-cycle bank swap pulse.
- o_underrun, out, 1, sticky: tick found holding register empty.
- o_overrun, out, 1, sticky: unaccepted result overwritten.
- i_clr_status, in, 1, clears both sticky flags.

Behaviour:
- Reset:
  - Every output is 0 except o_s_ready, which is 1.
  - State IDLE, tick counter 0, holding register empty, latency shift register 0.
- Tick:
  - Counter runs 0..CLK_DIV-1 while state ≠ IDLE.
  - A tick occurs in the cycle where count == CLK_DIV-1; the counter wraps to 0.
- States:
  - IDLE → RUN when i_enable=1; if a flush was pending, IDLE → FLUSH instead.
  - RUN → SWAP_WAIT on i_cfg_commit.
  - SWAP_WAIT → FLUSH on the next tick. In that same cycle o_bank_swap=1 and o_fir_en=1.
  - FLUSH → RUN after FIR_LENGTH+PIPE_LAT ticks.
  - Any state → IDLE when i_enable=0. The counter resets, and a pending swap or flush is retained.
- Input holding register:
  - o_s_ready = !hold_valid || tick.
  - The sample is captured when i_s_valid && o_s_ready.
  - Simultaneous tick and capture: the held sample goes to the filter and the new sample replaces it.
- Feed on tick (any non-IDLE state):
  - o_fir_data <= held sample; o_fir_en=1 for exactly one cycle, registered so it coincides with the o_fir_data update.
  - If the holding register is empty: feed 0, set o_underrun, and mark the latency slot invalid.
- Latency tracking:
  - A PIPE_LAT-deep valid shift register advances on each tick.
  - In the cycle after a tick whose tail bit is 1 and state==RUN, capture i_fir_data into o_m_data and set o_m_valid.
  - Results produced during FLUSH are dropped silently; o_overrun is not set.
- Output handshake:
  - o_m_valid clears on i_m_ready.
  - If a new capture arrives while o_m_valid=1 and i_m_ready=0: overwrite o_m_data and set o_overrun.
  - Capture and accept in the same cycle: the new value wins and o_overrun is not set.
- Config path:
  - When !o_cfg_busy, i_cfg_we is registered to o_coef_we/addr/data with 1-cycle latency.
  - Writes with addr ≥ FIR_LENGTH are dropped.
  - While o_cfg_busy: writes are dropped and i_cfg_commit is ignored.
- Sticky flags: i_clr_status clears both flags; a set event in the same cycle wins.
- Widths: samples pass through unmodified; no arithmetic beyond the counters.

Test Plan (CLK_DIV=4, PIPE_LAT=2, FIR_LENGTH=5):
1. Reset mid-run, with o_m_valid=1 and state FLUSH → next cycle: all outputs 0, o_s_ready=1, state IDLE.
2. i_enable=1, then samples 100, 200, 300 offered early in each tick period → o_fir_en exactly every 4 cycles. o_fir_data=100, 200, 300. o_m_valid rises the cycle after the 3rd tick, capturing i_fir_data. No status flags set.
3. No input for 2 ticks → o_fir_data=0 on both ticks and o_underrun=1. No o_m_valid for those slots. i_clr_status clears the flag.
4. i_m_ready=0 across two result captures with i_fir_data=7 then 9 → o_m_data=9 and o_overrun=1. Asserting i_m_ready drops o_m_valid.
5. Write addr 2 = 0x1234, then commit → o_coef_we pulses with addr 2 and data 0x1234. o_bank_swap coincides with the next o_fir_en. No o_m_valid for 7 ticks. A write during FLUSH produces no o_coef_we.
6. i_enable=0 during FLUSH, then re-enabled → state FLUSH. The full 7-tick suppression is repeated, then RUN.
